// File: rtl/current_mirror_pkg.sv
// Shared types and constants for the current-mirror bank.
//   cm_state_t  : per-channel ramp state (IDLE / RAMP)
//   K0_DEFAULT  : default offset coefficient of the mirror gain
//   KU_DEFAULT  : default gain per code LSB
//   cm_to_q     : real coefficient -> fixed point with SCALE_FRAC fraction bits
//   cm_scale_q  : channel scale -(K0 + KU*code) in the same fixed-point format
// Currents (pwl values) are signed PWL_W-bit integers in nA.
package current_mirror_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } cm_state_t;

  localparam real K0_DEFAULT = 0.0;
  localparam real KU_DEFAULT = 0.74;

  localparam int unsigned PWL_W      = 32;
  localparam int unsigned SCALE_FRAC = 24;
  localparam longint      ROUND_HALF = longint'(1) <<< (SCALE_FRAC - 1);

  // Real-to-integer cast rounds to nearest, so 0.74 maps to the closest Q24 value.
  function automatic longint cm_to_q(input real x);
    return longint'(x * 16777216.0);
  endfunction

  function automatic longint cm_scale_q(input longint k0_q, input longint ku_q,
                                        input int unsigned code);
    return -(k0_q + ku_q * longint'(code));
  endfunction

endpackage

// File: rtl/cm_ramp_ch.sv
// One mirror channel: target/code registers, step divider and settled flag.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : channel enable (low forces code to 0, keeps target)
//   accept    : config accept addressed to this channel
//   new_code  : target code carried by the accept
//   code      : currently applied gain code
//   settled   : enabled, idle and code == target
//   busy      : channel is ramping (blocks new accepts)
module cm_ramp_ch
  import current_mirror_pkg::*;
#(
  parameter int unsigned CODE_W   = 4,
  parameter int unsigned RAMP_DIV = 4,
  parameter int unsigned DEF_CODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              accept,
  input  logic [CODE_W-1:0] new_code,
  output logic [CODE_W-1:0] code,
  output logic              settled,
  output logic              busy
);

  localparam int unsigned       DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);

  cm_state_t         state_q, state_d;
  logic [CODE_W-1:0] target_q, target_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              en_q;
  logic              settled_q, settled_d;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    code_d   = code_q;
    div_d    = div_q;

    if (accept) target_d = new_code;

    if (!en) begin
      code_d  = '0;
      div_d   = '0;
      state_d = IDLE;
    end else if (accept) begin
      div_d   = '0;
      state_d = (new_code != code_q) ? RAMP : IDLE;
    end else if (!en_q) begin
      // Re-enable: code is 0 here, so climb back to the retained target.
      div_d   = '0;
      state_d = (target_q != '0) ? RAMP : IDLE;
    end else if (state_q == RAMP) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        code_d = (target_q > code_q) ? code_q + 1'b1 : code_q - 1'b1;
        if (code_d == target_q) state_d = IDLE;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    settled_d = (state_d == IDLE) && (code_d == target_d);
  end

  // en_q resets high so a channel enabled through reset does not see a false rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= CODE_W'(DEF_CODE);
      code_q    <= CODE_W'(DEF_CODE);
      div_q     <= '0;
      en_q      <= 1'b1;
      settled_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      code_q    <= code_d;
      div_q     <= div_d;
      en_q      <= en;
      settled_q <= settled_d;
    end
  end

  // Gating with en makes settled follow en during reset and drop as soon as en falls.
  assign settled = settled_q & en;
  assign code    = code_q;
  assign busy    = (state_q == RAMP);

endmodule

// File: rtl/current_mirror_bank.sv
// Multi-channel current-mirror bank with per-channel soft-ramped gain codes.
// out[i] = -(K0 + KU*code[i]) * iref when en[i], else 0.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   vdd, vss            : supplies, pass-through only
//   iref                : reference current (signed nA)
//   cfg_valid/cfg_ready : config handshake; cfg_ch selects channel, cfg_code the target
//   en                  : per-channel enable
//   code                : applied code per channel, channel i at [i*CODE_W +: CODE_W]
//   settled             : per-channel settled flag
//   out                 : mirrored currents, channel i at [i*PWL_W +: PWL_W]
module current_mirror_bank
  import current_mirror_pkg::*;
#(
  parameter int unsigned NCH      = 2,
  parameter int unsigned CODE_W   = 4,
  parameter int unsigned RAMP_DIV = 4,
  parameter int unsigned DEF_CODE = 1,
  parameter real         K0       = K0_DEFAULT,
  parameter real         KU       = KU_DEFAULT,
  localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PWL_W-1:0]      vdd,
  input  logic [PWL_W-1:0]      vss,
  input  logic [PWL_W-1:0]      iref,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [CODE_W-1:0]     cfg_code,
  input  logic [NCH-1:0]        en,
  output logic [NCH*CODE_W-1:0] code,
  output logic [NCH-1:0]        settled,
  output logic [NCH*PWL_W-1:0]  out
);

  localparam longint K0_Q = cm_to_q(K0);
  localparam longint KU_Q = cm_to_q(KU);

  logic [NCH-1:0] busy;
  logic [NCH-1:0] accept;

  // Out-of-range channels are always ready; their accepts match no channel and vanish.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !busy[i];
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CODE_W-1:0]  ch_code;
    logic signed [63:0] scale_q;
    logic signed [63:0] prod;

    assign accept[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));

    cm_ramp_ch #(
      .CODE_W   (CODE_W),
      .RAMP_DIV (RAMP_DIV),
      .DEF_CODE (DEF_CODE)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .accept   (accept[i]),
      .new_code (cfg_code),
      .code     (ch_code),
      .settled  (settled[i]),
      .busy     (busy[i])
    );

    assign code[i*CODE_W +: CODE_W] = ch_code;

    // pwl_add/scale: fixed-point scale times iref, rounded back to nA.
    assign scale_q = cm_scale_q(K0_Q, KU_Q, 32'(ch_code));
    assign prod    = scale_q * 64'($signed(iref));
    assign out[i*PWL_W +: PWL_W] = en[i] ? PWL_W'((prod + ROUND_HALF) >>> SCALE_FRAC) : '0;
  end

endmodule

// File: tb/tb_current_mirror_bank.sv
module tb_current_mirror_bank;

  logic        clk;
  logic        rst;
  logic [31:0] vdd;
  logic [31:0] vss;
  logic [31:0] iref;

  // Main DUT, NCH=2
  logic        cfg_valid;
  logic        cfg_ready;
  logic [0:0]  cfg_ch;
  logic [3:0]  cfg_code;
  logic [1:0]  en;
  logic [7:0]  code;
  logic [1:0]  settled;
  logic [63:0] out_w;

  // Second DUT, NCH=3, for out-of-range channel selects
  logic        cfg_valid3;
  logic        cfg_ready3;
  logic [1:0]  cfg_ch3;
  logic [3:0]  cfg_code3;
  logic [2:0]  en3;
  logic [11:0] code3;
  logic [2:0]  settled3;
  logic [95:0] out3;

  int checks = 0;
  int errors = 0;

  current_mirror_bank #(.NCH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .vdd       (vdd),
    .vss       (vss),
    .iref      (iref),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_code  (cfg_code),
    .en        (en),
    .code      (code),
    .settled   (settled),
    .out       (out_w)
  );

  current_mirror_bank #(.NCH(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .vdd       (vdd),
    .vss       (vss),
    .iref      (iref),
    .cfg_valid (cfg_valid3),
    .cfg_ready (cfg_ready3),
    .cfg_ch    (cfg_ch3),
    .cfg_code  (cfg_code3),
    .en        (en3),
    .code      (code3),
    .settled   (settled3),
    .out       (out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    vdd        = 32'd1800;
    vss        = 32'd0;
    iref       = 32'd100000;
    en         = 2'b11;
    cfg_valid  = 1'b0;
    cfg_ch     = 1'b0;
    cfg_code   = 4'd0;
    en3        = 3'b111;
    cfg_valid3 = 1'b0;
    cfg_ch3    = 2'd0;
    cfg_code3  = 4'd0;

    // Reset state
    step(2);
    chk("rst_code0", code[3:0], 1);
    chk("rst_code1", code[7:4], 1);
    chk("rst_settled", settled, 2'b11);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_out0", $signed(out_w[31:0]), -74000);
    chk("rst_out1", $signed(out_w[63:32]), -74000);
    rst = 1'b0;
    step(1);

    // Ramp ch0 1 -> 5
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_code = 4'd5;
    #1 chk("up_ready_pre", cfg_ready, 1);
    step(1);
    cfg_valid = 1'b0;
    chk("up_ready_busy", cfg_ready, 0);
    chk("up_settled_k", settled, 2'b10);
    chk("up_code_k", code[3:0], 1);
    cfg_ch = 1'b1;
    #1 chk("up_ready_ch1", cfg_ready, 1);
    cfg_ch = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      step(3);
      chk("up_code_hold", code[3:0], n);
      chk("up_settled_low", settled[0], 0);
      step(1);
      chk("up_code_step", code[3:0], n + 1);
    end
    chk("up_settled_end", settled, 2'b11);
    chk("up_ready_end", cfg_ready, 1);
    chk("up_out0", $signed(out_w[31:0]), -370000);
    chk("up_code1", code[7:4], 1);

    // Ch1 1 -> 5, then down to 2 with a stalled accept behind it
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_code = 4'd5;
    step(1);
    cfg_valid = 1'b0;
    step(16);
    chk("c1_code5", code[7:4], 5);
    chk("c1_settled5", settled, 2'b11);
    cfg_valid = 1'b1; cfg_code = 4'd2;
    step(1);
    cfg_code = 4'd4;
    #1 chk("dn_ready_stall", cfg_ready, 0);
    step(4);
    chk("dn_code4", code[7:4], 4);
    chk("dn_ready_stall2", cfg_ready, 0);
    step(4);
    chk("dn_code3", code[7:4], 3);
    step(4);
    chk("dn_code2", code[7:4], 2);
    chk("dn_settled", settled, 2'b11);
    chk("dn_ready_idle", cfg_ready, 1);
    step(1);
    cfg_valid = 1'b0;
    chk("stall_take_code", code[7:4], 2);
    chk("stall_take_settled", settled, 2'b01);
    chk("stall_take_ready", cfg_ready, 0);
    step(4);
    chk("stall_code3", code[7:4], 3);
    step(4);
    chk("stall_code4", code[7:4], 4);
    chk("stall_settled", settled, 2'b11);

    // Disable ch0 mid-ramp, then re-enable
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_code = 4'd1;
    step(1);
    cfg_valid = 1'b0;
    step(16);
    chk("en_code1", code[3:0], 1);
    cfg_valid = 1'b1; cfg_code = 4'd5;
    step(1);
    cfg_valid = 1'b0;
    step(8);
    chk("en_code3", code[3:0], 3);
    en = 2'b10;
    #1 chk("en_out0_off", $signed(out_w[31:0]), 0);
    step(1);
    chk("en_code0", code[3:0], 0);
    chk("en_settled_off", settled, 2'b10);
    chk("en_ready_off", cfg_ready, 1);
    step(2);
    chk("en_code0_hold", code[3:0], 0);
    en = 2'b11;
    step(1);
    chk("re_code0", code[3:0], 0);
    chk("re_settled", settled, 2'b10);
    chk("re_ready", cfg_ready, 0);
    for (int n = 1; n <= 5; n++) begin
      step(3);
      chk("re_code_hold", code[3:0], n - 1);
      step(1);
      chk("re_code_step", code[3:0], n);
    end
    chk("re_settled_end", settled, 2'b11);
    chk("re_out0", $signed(out_w[31:0]), -370000);

    // Reset mid-ramp on ch1 (4 -> 1)
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_code = 4'd1;
    step(1);
    cfg_valid = 1'b0;
    step(4);
    chk("mr_code3", code[7:4], 3);
    rst = 1'b1;
    #1;
    chk("mr_code1_now", code[7:4], 1);
    chk("mr_code0_now", code[3:0], 1);
    chk("mr_settled_now", settled, 2'b11);
    chk("mr_ready_now", cfg_ready, 1);
    step(1);
    rst = 1'b0;
    step(10);
    chk("mr_code1_after", code[7:4], 1);
    chk("mr_code0_after", code[3:0], 1);
    chk("mr_settled_after", settled, 2'b11);
    chk("mr_out1", $signed(out_w[63:32]), -74000);

    // Accept with target == code
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_code = 4'd1;
    #1 chk("eq_ready_pre", cfg_ready, 1);
    step(1);
    cfg_valid = 1'b0;
    chk("eq_settled_k", settled, 2'b11);
    chk("eq_code_k", code[3:0], 1);
    chk("eq_ready_k", cfg_ready, 1);
    step(1);
    chk("eq_settled_k1", settled, 2'b11);

    // Out-of-range channel on NCH=3, then a real ch2 update
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_code3 = 4'd7;
    #1 chk("oor_ready", cfg_ready3, 1);
    step(1);
    cfg_valid3 = 1'b0;
    chk("oor_code", code3, 12'h111);
    chk("oor_settled", settled3, 3'b111);
    step(4);
    chk("oor_code_later", code3, 12'h111);
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd2; cfg_code3 = 4'd2;
    step(1);
    cfg_valid3 = 1'b0;
    chk("ch2_settled_k", settled3, 3'b011);
    step(4);
    chk("ch2_code", code3, 12'h211);
    chk("ch2_settled", settled3, 3'b111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/current_mirror_bank.md
# current_mirror_bank

Parametrised, multi-channel current-mirror bank with a per-channel digital gain code and a glitch-free soft-ramp controller. Each output channel mirrors `iref` with gain `K0 + KU*code`, output sign negative (NMOS-driven). Gain updates arrive over a valid/ready config port, and each code steps one LSB at a time toward its target, avoiding current steps on the analog loads. It sits between the bias generator (`iref`) and the downstream analog consumers, replacing the fixed two-output, two-bit mirror.

## Interface
- `NCH`, 2, number of output channels (1..16)
- `CODE_W`, 4, gain code width
- `RAMP_DIV`, 4, clock cycles per code step (>=1)
- `DEF_CODE`, 1, code and target after reset
- `K0`, 0.0, real, offset coefficient
- `KU`, 0.74, real, gain per code LSB (DEF_CODE=1 gives the nominal 0.74 mirror ratio)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `vdd`, `vss`  in  pwl  supplies (pass-through, unused by the model)
- `iref`  in  pwl  reference current
- `cfg_valid`  in  1  config request
- `cfg_ready`  out  1  config accept
- `cfg_ch`  in  max(1,$clog2(NCH))  target channel
- `cfg_code`  in  CODE_W  target gain code
- `en`  in  NCH  per-channel enable
- `code`  out  NCH x CODE_W  current applied code per channel
- `settled`  out  NCH  code equals target and channel enabled
- `out`  out  NCH pwl  `out[i] = -(K0 + KU*code[i])*iref` when `en[i]`, else 0

## Operation
- Per-channel state is `IDLE` or `RAMP`, with registers `target`, `code` and divider `div` (0..RAMP_DIV-1).
- `cfg_ready` (combinational) is 1 when channel `cfg_ch` is `IDLE`, or when `cfg_ch >= NCH`. An accept with `cfg_ch >= NCH` is dropped.
- An accept is `cfg_valid & cfg_ready` at a rising edge:
  - Write `target`, clear `div`.
  - If the new target differs from `code` and `en` is 1, go to `RAMP`. Otherwise stay `IDLE`.
- In `RAMP`, `div` increments each cycle. When `div == RAMP_DIV-1`, `div` wraps to 0 and `code` moves by +1 or -1 toward `target`. When `code` reaches `target`, the channel returns to `IDLE`.
- `en[i]` low forces `code` to 0, `div` to 0 and state to `IDLE`. `target` is retained.
- On a rising edge of `en[i]`, if `target != 0`, the channel enters `RAMP` from code 0. No reconfiguration is needed.
- Code arithmetic is unsigned `CODE_W` and never wraps. A target is always in range, so saturation cannot occur.
- `settled[i] = en[i] & (code == target) & IDLE`. It is registered, consistent with the state.
- `out` is updated from the registered `code` through a `pwl_add`/scale primitive. No analog state is held in the model.

## Timing
- Reset (asynchronous, while `rst`=1): all `code`=DEF_CODE, `target`=DEF_CODE, `div`=0, state `IDLE`.
  - `settled[i]` = `en[i]`.
  - `cfg_ready` = 1.
  - `out` reflects DEF_CODE for enabled channels.
- Reset mid-ramp aborts the ramp immediately to the reset values.
- After an accept at edge k: state and `settled` change at edge k. The first code step occurs at edge k+RAMP_DIV, the n-th at k+n*RAMP_DIV.
- Total settle latency is `|target-code|*RAMP_DIV` cycles. `settled` rises at the edge of the final step.
- An accept with `target == code` keeps `settled` high with no transient.
- `cfg_ready` for a ramping channel is low from edge k until the edge that returns it to `IDLE`.
- Simultaneous events in one cycle:
  - `en[i]` falling with an accept to channel i: `target` is written, and `code` goes to 0 in `IDLE`.
  - Accepts to different channels in consecutive cycles are independent.
- Only one accept is possible per cycle.

## Structure
- Package `current_mirror_pkg` holds:
  - `cm_state_t` enum {IDLE, RAMP}
  - the default `K0`/`KU` constants
  - a function computing the channel scale, `-(K0+KU*code)`
- Sub-module `cm_ramp_ch`: one channel's state, divider, code and settled logic, instantiated NCH times via generate. The top level holds the config decode and the per-channel `pwl_add` instances.

## Test plan
- Reset with `en`=2'b11, `iref`=100 uA → code=1/1, settled=11, `cfg_ready`=1, `out`=-74 uA on both channels.
- Accept ch0 code=5, RAMP_DIV=4 → code0 = 2, 3, 4, 5 at +4/+8/+12/+16 cycles. `settled[0]` low until +16. `cfg_ready` low for ch0 and high for ch1 throughout. `out0` = -370 uA at the end.
- Ramp down ch1 from 5 to 2 → three steps, 12 cycles. An accept to ch1 during the ramp is stalled until `IDLE`, then takes effect.
- Drop `en[0]` at code 3 of a 1→5 ramp → code0=0, out0=0, target kept. Raise `en[0]` → ramp 0→5 in 20 cycles.
- Assert `rst` mid-ramp for one cycle → code=DEF_CODE immediately, state `IDLE`, no further steps.
- `cfg_ch`=3 with NCH=3, and `target == code` on a valid channel → `cfg_ready`=1, no state change, `settled` unchanged.
